// File: rtl/axi_ddr_stub.sv
// AXI4 slave that stands in for a DDR3 controller user port: on-chip word memory,
// INCR bursts, one transaction in flight, emulated calibration delay after reset.
module axi_ddr_stub #(
   parameter int DATA_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 28,
   parameter int ID_WIDTH    = 4,
   parameter int DEPTH_LOG2  = 10,
   parameter int INIT_CYCLES = 200
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   output logic                    init_done,

   input  logic                    axi_awvalid,
   output logic                    axi_awready,
   input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
   input  logic [ID_WIDTH-1:0]     axi_awid,
   input  logic [7:0]              axi_awlen,

   input  logic                    axi_wvalid,
   output logic                    axi_wready,
   input  logic [DATA_WIDTH-1:0]   axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
   input  logic                    axi_wlast,

   output logic                    axi_bvalid,
   input  logic                    axi_bready,
   output logic [ID_WIDTH-1:0]     axi_bid,
   output logic [1:0]              axi_bresp,

   input  logic                    axi_arvalid,
   output logic                    axi_arready,
   input  logic [ADDR_WIDTH-1:0]   axi_araddr,
   input  logic [ID_WIDTH-1:0]     axi_arid,
   input  logic [7:0]              axi_arlen,

   output logic                    axi_rvalid,
   input  logic                    axi_rready,
   output logic [DATA_WIDTH-1:0]   axi_rdata,
   output logic [ID_WIDTH-1:0]     axi_rid,
   output logic [1:0]              axi_rresp,
   output logic                    axi_rlast
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int CNT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {INIT, IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        init_cnt;
   logic                    prefer_write;
   logic [ID_WIDTH-1:0]     wr_id;
   logic [ID_WIDTH-1:0]     rd_id;
   logic [DEPTH_LOG2-1:0]   wr_idx;
   logic [DEPTH_LOG2-1:0]   rd_idx;
   logic [8:0]              wr_left;
   logic [8:0]              rd_left;
   logic                    wr_err;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_q;

   logic                    aw_fire;
   logic                    ar_fire;
   logic                    w_fire;
   logic                    rd_load;
   logic                    unused_addr;

   // Address readies look at the opposing valid so a single cycle can never complete both handshakes.
   assign axi_awready = (state == IDLE) && (prefer_write || !axi_arvalid);
   assign axi_arready = (state == IDLE) && (!prefer_write || !axi_awvalid);

   assign aw_fire = axi_awvalid && axi_awready;
   assign ar_fire = axi_arvalid && axi_arready;
   assign w_fire  = sys_rst_n && axi_wvalid && axi_wready;

   // The output word is refetched only when empty or when the presented beat is consumed.
   assign rd_load = (state == RD_DATA) && (!axi_rvalid || (axi_rready && !axi_rlast));

   assign axi_bid     = wr_id;
   assign axi_rid     = rd_id;
   assign axi_rdata   = rd_q;
   assign axi_rresp   = 2'b00;
   assign unused_addr = ^{axi_awaddr, axi_araddr};

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state        <= INIT;
         init_cnt     <= '0;
         init_done    <= 1'b0;
         prefer_write <= 1'b1;
         axi_wready   <= 1'b0;
         axi_bvalid   <= 1'b0;
         axi_bresp    <= 2'b00;
         axi_rvalid   <= 1'b0;
         axi_rlast    <= 1'b0;
         wr_err       <= 1'b0;
         wr_id        <= '0;
         rd_id        <= '0;
         wr_idx       <= '0;
         rd_idx       <= '0;
         wr_left      <= '0;
         rd_left      <= '0;
      end else begin
         case (state)
            INIT: begin
               if (int'(init_cnt) + 1 >= INIT_CYCLES) begin
                  init_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end

            IDLE: begin
               if (aw_fire) begin
                  wr_id        <= axi_awid;
                  wr_idx       <= axi_awaddr[OFF +: DEPTH_LOG2];
                  wr_left      <= {1'b0, axi_awlen} + 9'd1;
                  wr_err       <= 1'b0;
                  axi_wready   <= 1'b1;
                  prefer_write <= 1'b0;
                  state        <= WR_DATA;
               end else if (ar_fire) begin
                  rd_id        <= axi_arid;
                  rd_idx       <= axi_araddr[OFF +: DEPTH_LOG2];
                  rd_left      <= {1'b0, axi_arlen} + 9'd1;
                  prefer_write <= 1'b1;
                  state        <= RD_DATA;
               end
            end

            WR_DATA: begin
               if (w_fire) begin
                  wr_idx  <= wr_idx + DEPTH_LOG2'(1);
                  wr_left <= wr_left - 9'd1;
                  // The beat count alone ends the burst; a misplaced wlast only taints the response.
                  if (wr_left == 9'd1) begin
                     axi_wready <= 1'b0;
                     axi_bvalid <= 1'b1;
                     axi_bresp  <= (wr_err || !axi_wlast) ? 2'b10 : 2'b00;
                     state      <= WR_RESP;
                  end else if (axi_wlast) begin
                     wr_err <= 1'b1;
                  end
               end
            end

            WR_RESP: begin
               if (axi_bready) begin
                  axi_bvalid <= 1'b0;
                  state      <= IDLE;
               end
            end

            RD_DATA: begin
               if (rd_load) begin
                  rd_idx     <= rd_idx + DEPTH_LOG2'(1);
                  rd_left    <= rd_left - 9'd1;
                  axi_rvalid <= 1'b1;
                  axi_rlast  <= (rd_left == 9'd1);
               end else if (axi_rvalid && axi_rready && axi_rlast) begin
                  axi_rvalid <= 1'b0;
                  axi_rlast  <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: state <= INIT;
         endcase
      end
   end

   // Storage is deliberately left unreset so that a reset mid-burst preserves earlier writes.
   always_ff @(posedge sys_clk) begin
      if (w_fire) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (axi_wstrb[b]) begin
               mem[wr_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
            end
         end
      end
      if (rd_load) begin
         rd_q <= mem[rd_idx];
      end
   end

endmodule

// File: doc/axi_ddr_stub.md
AXI_DDR_STUB -- requirements
Module: axi_ddr_stub

Interface
REQ-001 Parameters: DATA_WIDTH, default 128, AXI data width in bits (power of two, >=16).
REQ-002 Parameters: ADDR_WIDTH, default 28, AXI byte-address width.
REQ-003 Parameters: ID_WIDTH, default 4, AXI ID width.
REQ-004 Parameters: DEPTH_LOG2, default 10, log2 of on-chip memory depth in DATA_WIDTH words.
REQ-005 Parameters: INIT_CYCLES, default 200, cycles from reset release to init_done.
REQ-006 Ports: sys_clk input 1, the single clock; sys_rst_n input 1, reset that is synchronous and active-low.
REQ-007 Ports: init_done output 1, calibration-complete emulation.
REQ-008 Ports: AW channel: axi_awvalid in 1, axi_awready out 1, axi_awaddr in ADDR_WIDTH, axi_awid in ID_WIDTH, axi_awlen in 8.
REQ-009 Ports: W channel: axi_wvalid in 1, axi_wready out 1, axi_wdata in DATA_WIDTH, axi_wstrb in DATA_WIDTH/8, axi_wlast in 1.
REQ-010 Ports: B channel: axi_bvalid out 1, axi_bready in 1, axi_bid out ID_WIDTH, axi_bresp out 2.
REQ-011 Ports: AR channel: axi_arvalid in 1, axi_arready out 1, axi_araddr in ADDR_WIDTH, axi_arid in ID_WIDTH, axi_arlen in 8.
REQ-012 Ports: R channel: axi_rvalid out 1, axi_rready in 1, axi_rdata out DATA_WIDTH, axi_rid out ID_WIDTH, axi_rresp out 2, axi_rlast out 1.

Function
REQ-013 Block is the AXI responder standing in for the DDR3 controller user port; INCR bursts only, one transaction outstanding.
REQ-014 Word index = (addr >> log2(DATA_WIDTH/8)) mod 2^DEPTH_LOG2; low unaligned bits ignored; each beat increments index by 1, wrapping from 2^DEPTH_LOG2-1 to 0.
REQ-015 FSM states: INIT, IDLE, WR_DATA, WR_RESP, RD_DATA.
REQ-016 INIT: counter runs INIT_CYCLES cycles after reset release, then init_done=1 (sticky until reset), go IDLE; all readies 0 while in INIT.
REQ-017 IDLE: axi_awready and axi_arready asserted only in IDLE; one handshake accepted per cycle.
REQ-018 Simultaneous awvalid and arvalid in IDLE: round-robin, the channel not served last wins; after reset write wins first.
REQ-019 AW handshake: latch id, index, beat count = awlen+1; go WR_DATA.
REQ-020 WR_DATA: axi_wready=1; each W handshake writes bytes with wstrb=1, leaves others unchanged; after awlen+1 beats go WR_RESP.
REQ-021 axi_wlast mismatch (asserted early or absent on final beat) sets bresp=2'b10 (SLVERR); burst still ends on beat count; otherwise bresp=2'b00.
REQ-022 WR_RESP: axi_bvalid=1 with latched bid/bresp held stable until bready; then IDLE.
REQ-023 AR handshake: latch id, index, length; go RD_DATA; first axi_rvalid exactly 2 cycles after AR handshake cycle.
REQ-024 RD_DATA: rdata/rid/rlast held stable while rvalid=1 and rready=0; back-to-back beats with no bubble when rready stays 1; rresp always 2'b00.
REQ-025 axi_rlast=1 only on beat awlen/arlen+1; after its handshake return to IDLE.
REQ-026 Memory array not reset; contents before first write undefined (X in simulation).

Reset
REQ-027 sys_rst_n sampled on sys_clk rising edge only; while low: state INIT, init counter 0, init_done=0, all ready/valid outputs 0, bresp/rresp 0, rlast 0, round-robin pointer to write.
REQ-028 Reset mid-burst abandons the transaction; no B or R beat issued afterwards; memory words already written retain value.

Verification
REQ-029 Reset release, INIT_CYCLES=200 -> init_done rises on cycle 200 after release; awready/arready 0 before, 1 after.
REQ-030 Write awaddr=0x0, awlen=3, wdata 0x11..,0x22..,0x33..,0x44.., wstrb all 1s, wlast on beat 4 -> bresp=00; read same, arlen=3 -> same 4 words, rlast on beat 4, first rvalid 2 cycles after AR.
REQ-031 Write at word 1023 (DEPTH_LOG2=10), awlen=1 -> second beat lands at word 0; read-back confirms wrap.
REQ-032 Partial write wstrb=0x000F over word of 0xFF..FF with data 0 -> low 4 bytes 0, rest 0xFF; wlast on beat 1 of a 2-beat burst -> bresp=2'b10.
REQ-033 awvalid and arvalid asserted together twice -> write served first, then read; rready toggled randomly -> rdata stable while stalled, no beats lost.
REQ-034 sys_rst_n low during read beat 2 of 8 -> rvalid 0 next cycle, init_done 0, no further R beats.
